nbit_register_file: RTL and testbench

Parametrised register file built on the N-bit register primitive: 2**ADDR_WIDTH words of WIDTH bits, one synchronous write port and two independently enabled, registered read ports. Same-edge write-to-read bypass (write-first) and an optional hardwired-zero register 0. Serves as the general-purpose register bank for the lab datapath, replacing standalone N-bit registers.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/nbit_enable_register.sv | 20 ++
 rtl/nbit_register_file.sv | 72 +++++++
 tb/tb_nbit_register_file.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing constants for the datapath register bank and its bench.
package regfile_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 3;
  localparam int unsigned DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

  // Number of words addressed by an addr_width-bit address
  function automatic int unsigned regfile_depth(input int unsigned addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/nbit_enable_register.sv
// WIDTH-bit register with load enable and asynchronous active-low clear.
module nbit_enable_register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      Q <= '0;
    end else if (Load) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/nbit_register_file.sv
// Register bank: one write port, two registered read ports with write-first
// bypass, and an optional hardwired-zero word 0.
module nbit_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  Write_en,
  input  logic [ADDR_WIDTH-1:0] Write_addr,
  input  logic [WIDTH-1:0]      Data_in,
  input  logic                  Read_en_a,
  input  logic [ADDR_WIDTH-1:0] Read_addr_a,
  output logic [WIDTH-1:0]      Data_out_a,
  input  logic                  Read_en_b,
  input  logic [ADDR_WIDTH-1:0] Read_addr_b,
  output logic [WIDTH-1:0]      Data_out_b
);

  localparam int unsigned DEPTH = regfile_depth(ADDR_WIDTH);

  logic [WIDTH-1:0] word_q [DEPTH];
  logic [WIDTH-1:0] rd_data_a_c;
  logic [WIDTH-1:0] rd_data_b_c;
  logic             bypass_a_c;
  logic             bypass_b_c;
  logic             wr_live_c;

  // Storage words; word 0 is a constant when hardwired to zero
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign word_q[i] = '0;
    end else begin : g_reg
      nbit_enable_register #(.WIDTH(WIDTH)) u_word (
        .Clock (Clock),
        .Clear (Clear),
        .Load  (Write_en && (Write_addr == ADDR_WIDTH'(i))),
        .D     (Data_in),
        .Q     (word_q[i])
      );
    end
  end

  // A write to the hardwired zero word never reaches the read path
  always_comb begin
    wr_live_c   = Write_en && !((ZERO_REG != 0) && (Write_addr == '0));
    bypass_a_c  = wr_live_c && (Read_addr_a == Write_addr);
    bypass_b_c  = wr_live_c && (Read_addr_b == Write_addr);
    rd_data_a_c = bypass_a_c ? Data_in : word_q[Read_addr_a];
    rd_data_b_c = bypass_b_c ? Data_in : word_q[Read_addr_b];
  end

  nbit_enable_register #(.WIDTH(WIDTH)) u_out_a (
    .Clock (Clock),
    .Clear (Clear),
    .Load  (Read_en_a),
    .D     (rd_data_a_c),
    .Q     (Data_out_a)
  );

  nbit_enable_register #(.WIDTH(WIDTH)) u_out_b (
    .Clock (Clock),
    .Clear (Clear),
    .Load  (Read_en_b),
    .D     (rd_data_b_c),
    .Q     (Data_out_b)
  );

endmodule

// File: tb/tb_nbit_register_file.sv
// Directed bench: two 4-bit, 8-word instances sharing stimulus, one with a
// hardwired zero word and one without.
module tb_nbit_register_file;

  localparam int unsigned W  = 4;
  localparam int unsigned AW = 3;

  logic          Clock;
  logic          Clear;
  logic          Write_en;
  logic [AW-1:0] Write_addr;
  logic [W-1:0]  Data_in;
  logic          Read_en_a;
  logic [AW-1:0] Read_addr_a;
  logic          Read_en_b;
  logic [AW-1:0] Read_addr_b;
  logic [W-1:0]  z_out_a, z_out_b;
  logic [W-1:0]  n_out_a, n_out_b;

  int checks = 0;
  int errors = 0;

  nbit_register_file #(.WIDTH(W), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut_z (
    .Clock(Clock), .Clear(Clear), .Write_en(Write_en), .Write_addr(Write_addr),
    .Data_in(Data_in), .Read_en_a(Read_en_a), .Read_addr_a(Read_addr_a),
    .Data_out_a(z_out_a), .Read_en_b(Read_en_b), .Read_addr_b(Read_addr_b),
    .Data_out_b(z_out_b)
  );

  nbit_register_file #(.WIDTH(W), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_n (
    .Clock(Clock), .Clear(Clear), .Write_en(Write_en), .Write_addr(Write_addr),
    .Data_in(Data_in), .Read_en_a(Read_en_a), .Read_addr_a(Read_addr_a),
    .Data_out_a(n_out_a), .Read_en_b(Read_en_b), .Read_addr_b(Read_addr_b),
    .Data_out_b(n_out_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [AW-1:0] addr, input logic [W-1:0] data);
    Write_en   = en;
    Write_addr = addr;
    Data_in    = data;
  endtask

  initial begin
    Clear       = 1'b0;
    set_wr(1'b1, 3'd1, 4'hF);
    Read_en_a   = 1'b1;
    Read_addr_a = 3'd1;
    Read_en_b   = 1'b1;
    Read_addr_b = 3'd1;

    // Clear held low: writes and reads have no effect
    step();
    step();
    check("rst_z_a", z_out_a, 4'h0);
    check("rst_z_b", z_out_b, 4'h0);
    check("rst_n_a", n_out_a, 4'h0);
    check("rst_n_b", n_out_b, 4'h0);

    Clear = 1'b1;
    set_wr(1'b0, 3'd0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      Read_addr_a = AW'(i);
      Read_addr_b = AW'(7 - i);
      step();
      check($sformatf("rst_rd_z_a%0d", i), z_out_a, 4'h0);
      check($sformatf("rst_rd_n_b%0d", i), n_out_b, 4'h0);
    end

    // Write then read on both ports
    set_wr(1'b1, 3'd3, 4'hA);
    step();
    set_wr(1'b1, 3'd5, 4'h9);
    step();
    set_wr(1'b0, 3'd0, 4'h0);
    Read_addr_a = 3'd3;
    Read_addr_b = 3'd5;
    step();
    check("wr_z_a", z_out_a, 4'hA);
    check("wr_z_b", z_out_b, 4'h9);
    check("wr_n_a", n_out_a, 4'hA);
    check("wr_n_b", n_out_b, 4'h9);

    // Bypass: same-edge write and read of addr 2
    set_wr(1'b1, 3'd2, 4'h1);
    step();
    set_wr(1'b1, 3'd2, 4'h5);
    Read_addr_a = 3'd2;
    step();
    check("byp_z_a", z_out_a, 4'h5);
    check("byp_n_a", n_out_a, 4'h5);

    // Word 0: hardwired zero versus ordinary storage
    set_wr(1'b1, 3'd0, 4'h7);
    Read_addr_a = 3'd0;
    Read_addr_b = 3'd0;
    step();
    check("zero_byp_z_a", z_out_a, 4'h0);
    check("zero_byp_z_b", z_out_b, 4'h0);
    check("zero_byp_n_a", n_out_a, 4'h7);
    set_wr(1'b0, 3'd0, 4'h0);
    step();
    check("zero_after_z_a", z_out_a, 4'h0);
    check("zero_after_n_b", n_out_b, 4'h7);

    // Hold: port B keeps its value while disabled
    Read_en_a   = 1'b0;
    Read_addr_b = 3'd4;
    set_wr(1'b1, 3'd4, 4'hC);
    step();
    check("hold_load_z_b", z_out_b, 4'hC);
    Read_en_b = 1'b0;
    set_wr(1'b1, 3'd4, 4'h3);
    step();
    check("hold1_z_b", z_out_b, 4'hC);
    check("hold1_n_b", n_out_b, 4'hC);
    check("hold_a_z", z_out_a, 4'h0);
    check("hold_a_n", n_out_a, 4'h7);
    set_wr(1'b0, 3'd0, 4'h0);
    step();
    check("hold2_z_b", z_out_b, 4'hC);
    Read_en_b = 1'b1;
    step();
    check("hold_rel_z_b", z_out_b, 4'h3);
    check("hold_rel_n_b", n_out_b, 4'h3);

    // Fill all words with 8+i and read them back
    Read_en_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_wr(1'b1, AW'(i), W'(8 + i));
      step();
    end
    set_wr(1'b0, 3'd0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      Read_addr_a = AW'(i);
      Read_addr_b = AW'(i);
      step();
      check($sformatf("fill_z_a%0d", i), z_out_a, (i == 0) ? 4'h0 : W'(8 + i));
      check($sformatf("fill_n_b%0d", i), n_out_b, W'(8 + i));
    end

    // Mid-cycle clear with a pending write and read
    set_wr(1'b1, 3'd6, 4'h2);
    Read_addr_a = 3'd6;
    #2;
    Clear = 1'b0;
    #1;
    check("mid_clr_z_a", z_out_a, 4'h0);
    check("mid_clr_z_b", z_out_b, 4'h0);
    check("mid_clr_n_a", n_out_a, 4'h0);
    check("mid_clr_n_b", n_out_b, 4'h0);
    step();
    Clear = 1'b1;
    set_wr(1'b0, 3'd0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      Read_addr_a = AW'(i);
      Read_addr_b = AW'(i);
      step();
      check($sformatf("post_clr_z_b%0d", i), z_out_b, 4'h0);
      check($sformatf("post_clr_n_a%0d", i), n_out_a, 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
